tcp_ip_header_parser: RTL and testbench

- Byte-serial parser that extracts the IPv4 and TCP header fields consumed by the decision-tree header mux.
- Input is the packet byte stream starting at the IPv4 header (no L2); output is a registered field bundle plus a one-cycle valid strobe per parsed packet.
- Sits between the packet ingress stream and the decision-tree node evaluation logic.
- Also keeps saturating good/bad packet counters for status readout.

---
 rtl/tcp_ip_header_parser.sv | 232 +++++++++++++++++++++++
 tb/tb_tcp_ip_header_parser.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_ip_header_parser.sv
// tcp_ip_header_parser
// Byte-serial IPv4 + TCP header field extractor. The stream starts at the
// IPv4 header. Fields are collected into shadow registers as they arrive and
// are published as one registered bundle when the TCP window LSB is accepted.
// Malformed or truncated packets raise a one-cycle error pulse. Saturating
// good/bad packet counters are kept for status readout.
module tcp_ip_header_parser #(
    parameter bit         CHECK_PROTO = 1'b1,
    parameter logic [7:0] TCP_PROTO   = 8'd6,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic [15:0]      l3_iph_tot_len,
    output logic [3:0]       l3_iph_ihl,
    output logic [7:0]       l3_iph_tos,
    output logic [15:0]      l3_iph_id,
    output logic             l3_iph_df,
    output logic [12:0]      l3_iph_frag_off,
    output logic [3:0]       l4_tcph_doff,
    output logic             l4_tcph_fin,
    output logic             l4_tcph_syn,
    output logic             l4_tcph_rst,
    output logic             l4_tcph_ack,
    output logic [15:0]      l4_tcph_window,
    output logic             hdr_valid,
    output logic             hdr_error,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_IP    = 3'd1,
        S_TCP   = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_t           state_q;
    logic [6:0]       off_q;
    // shadow registers, filled while the header streams past
    logic [3:0]       ihl_sh_q;
    logic [7:0]       tos_sh_q;
    logic [15:0]      tot_len_sh_q;
    logic [15:0]      id_sh_q;
    logic             df_sh_q;
    logic [12:0]      frag_sh_q;
    logic [3:0]       doff_sh_q;
    logic [3:0]       flags_sh_q;   // {ack, rst, syn, fin}
    logic [7:0]       win_hi_sh_q;
    // published field bundle
    logic [15:0]      tot_len_q;
    logic [3:0]       ihl_q;
    logic [7:0]       tos_q;
    logic [15:0]      id_q;
    logic             df_q;
    logic [12:0]      frag_q;
    logic [3:0]       doff_q;
    logic [3:0]       flags_q;
    logic [15:0]      win_q;
    logic             hdr_valid_q;
    logic             hdr_error_q;
    logic [CNT_W-1:0] good_cnt_q;
    logic [CNT_W-1:0] bad_cnt_q;

    logic             start_s;
    logic             parse_s;
    logic             abort_s;
    logic             in_ip_s;
    logic [6:0]       eff_off_s;
    logic [6:0]       off_next_s;
    logic [6:0]       ip_len_s;
    logic [6:0]       tcp_off_s;
    logic             ip_last_s;
    logic             byte_err_s;
    logic             done_s;
    logic             fail_s;

    // Decode the current byte: which header it belongs to, its offset, and
    // whether it completes or breaks the packet. A sop byte always counts as
    // IP offset 0 of a new packet.
    always_comb begin
        start_s    = in_valid & in_sop;
        parse_s    = 1'b0;
        abort_s    = 1'b0;
        case (state_q)
            S_IDLE, S_DRAIN, S_ERR: parse_s = start_s;
            S_IP, S_TCP: begin
                parse_s = in_valid;
                abort_s = start_s;
            end
            default: parse_s = 1'b0;
        endcase
        in_ip_s    = start_s | (state_q == S_IP);
        eff_off_s  = start_s ? 7'd0 : off_q;
        off_next_s = (eff_off_s == 7'd127) ? 7'd127 : eff_off_s + 7'd1;
        ip_len_s   = {1'b0, ihl_sh_q, 2'b00};
        tcp_off_s  = eff_off_s - ip_len_s;
        ip_last_s  = !start_s && (eff_off_s == (ip_len_s - 7'd1));
        byte_err_s = 1'b0;
        if (in_ip_s) begin
            if (eff_off_s == 7'd0) begin
                byte_err_s = (in_data[7:4] != 4'd4) || (in_data[3:0] < 4'd5);
            end else if (eff_off_s == 7'd9) begin
                byte_err_s = (CHECK_PROTO == 1'b1) && (in_data != TCP_PROTO);
            end else begin
                byte_err_s = 1'b0;
            end
        end else begin
            byte_err_s = 1'b0;
        end
        done_s = parse_s && !in_ip_s && (tcp_off_s == 7'd15);
        fail_s = parse_s && (byte_err_s || (in_eop && !done_s));
    end

    // Parser FSM, shadow capture, output publication and status counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            off_q        <= 7'd0;
            ihl_sh_q     <= 4'd0;
            tos_sh_q     <= 8'd0;
            tot_len_sh_q <= 16'd0;
            id_sh_q      <= 16'd0;
            df_sh_q      <= 1'b0;
            frag_sh_q    <= 13'd0;
            doff_sh_q    <= 4'd0;
            flags_sh_q   <= 4'd0;
            win_hi_sh_q  <= 8'd0;
            tot_len_q    <= 16'd0;
            ihl_q        <= 4'd0;
            tos_q        <= 8'd0;
            id_q         <= 16'd0;
            df_q         <= 1'b0;
            frag_q       <= 13'd0;
            doff_q       <= 4'd0;
            flags_q      <= 4'd0;
            win_q        <= 16'd0;
            hdr_valid_q  <= 1'b0;
            hdr_error_q  <= 1'b0;
            good_cnt_q   <= {CNT_W{1'b0}};
            bad_cnt_q    <= {CNT_W{1'b0}};
        end else begin
            hdr_valid_q <= 1'b0;
            hdr_error_q <= 1'b0;
            if (in_valid) begin
                off_q <= off_next_s;
            end
            if (parse_s) begin
                if (in_ip_s) begin
                    case (eff_off_s)
                        7'd0: ihl_sh_q            <= in_data[3:0];
                        7'd1: tos_sh_q            <= in_data;
                        7'd2: tot_len_sh_q[15:8]  <= in_data;
                        7'd3: tot_len_sh_q[7:0]   <= in_data;
                        7'd4: id_sh_q[15:8]       <= in_data;
                        7'd5: id_sh_q[7:0]        <= in_data;
                        7'd6: begin
                            df_sh_q          <= in_data[6];
                            frag_sh_q[12:8]  <= in_data[4:0];
                        end
                        7'd7: frag_sh_q[7:0]      <= in_data;
                        default: ;
                    endcase
                end else begin
                    case (tcp_off_s)
                        7'd12: doff_sh_q   <= in_data[7:4];
                        7'd13: flags_sh_q  <= {in_data[4], in_data[2], in_data[1], in_data[0]};
                        7'd14: win_hi_sh_q <= in_data;
                        default: ;
                    endcase
                end
            end
            // the sop-abort pulse and an error on the new sop byte share one pulse
            if (fail_s || abort_s) begin
                hdr_error_q <= 1'b1;
                bad_cnt_q   <= sat_inc(bad_cnt_q);
            end else if (done_s) begin
                hdr_valid_q <= 1'b1;
                good_cnt_q  <= sat_inc(good_cnt_q);
                tot_len_q   <= tot_len_sh_q;
                ihl_q       <= ihl_sh_q;
                tos_q       <= tos_sh_q;
                id_q        <= id_sh_q;
                df_q        <= df_sh_q;
                frag_q      <= frag_sh_q;
                doff_q      <= doff_sh_q;
                flags_q     <= flags_sh_q;
                win_q       <= {win_hi_sh_q, in_data};
            end
            if (fail_s) begin
                state_q <= in_eop ? S_IDLE : S_ERR;
            end else if (done_s) begin
                state_q <= in_eop ? S_IDLE : S_DRAIN;
            end else if (parse_s) begin
                state_q <= (in_ip_s && !ip_last_s) ? S_IP : S_TCP;
            end else if (in_valid && in_eop && ((state_q == S_DRAIN) || (state_q == S_ERR))) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_q;
            end
        end
    end

    assign l3_iph_tot_len  = tot_len_q;
    assign l3_iph_ihl      = ihl_q;
    assign l3_iph_tos      = tos_q;
    assign l3_iph_id       = id_q;
    assign l3_iph_df       = df_q;
    assign l3_iph_frag_off = frag_q;
    assign l4_tcph_doff    = doff_q;
    assign l4_tcph_fin     = flags_q[0];
    assign l4_tcph_syn     = flags_q[1];
    assign l4_tcph_rst     = flags_q[2];
    assign l4_tcph_ack     = flags_q[3];
    assign l4_tcph_window  = win_q;
    assign hdr_valid       = hdr_valid_q;
    assign hdr_error       = hdr_error_q;
    assign good_cnt        = good_cnt_q;
    assign bad_cnt         = bad_cnt_q;

endmodule

// File: tb/tb_tcp_ip_header_parser.sv
// Directed bench for tcp_ip_header_parser: builds packets byte by byte and
// checks published fields, pulse timing and counters against hand values.
module tb_tcp_ip_header_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_sop = 1'b0;
    logic        in_eop = 1'b0;

    logic [15:0] tot_len, id, window;
    logic [3:0]  ihl, doff;
    logic [7:0]  tos;
    logic        df, fin, syn, rst_f, ack, hdr_valid, hdr_error;
    logic [12:0] frag;
    logic [15:0] good_cnt, bad_cnt;

    logic [15:0] d2_tot_len, d2_id, d2_window;
    logic [3:0]  d2_ihl, d2_doff;
    logic [7:0]  d2_tos;
    logic        d2_df, d2_fin, d2_syn, d2_rst, d2_ack, d2_valid, d2_error;
    logic [12:0] d2_frag;
    logic [1:0]  d2_good, d2_bad;

    tcp_ip_header_parser dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop),
        .l3_iph_tot_len(tot_len), .l3_iph_ihl(ihl), .l3_iph_tos(tos),
        .l3_iph_id(id), .l3_iph_df(df), .l3_iph_frag_off(frag),
        .l4_tcph_doff(doff), .l4_tcph_fin(fin), .l4_tcph_syn(syn),
        .l4_tcph_rst(rst_f), .l4_tcph_ack(ack), .l4_tcph_window(window),
        .hdr_valid(hdr_valid), .hdr_error(hdr_error),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    tcp_ip_header_parser #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_sop(in_sop), .in_eop(in_eop),
        .l3_iph_tot_len(d2_tot_len), .l3_iph_ihl(d2_ihl), .l3_iph_tos(d2_tos),
        .l3_iph_id(d2_id), .l3_iph_df(d2_df), .l3_iph_frag_off(d2_frag),
        .l4_tcph_doff(d2_doff), .l4_tcph_fin(d2_fin), .l4_tcph_syn(d2_syn),
        .l4_tcph_rst(d2_rst), .l4_tcph_ack(d2_ack), .l4_tcph_window(d2_window),
        .hdr_valid(d2_valid), .hdr_error(d2_error),
        .good_cnt(d2_good), .bad_cnt(d2_bad)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int nvalid = 0;
    int nerror = 0;
    int vcyc = -1;
    int ecyc = -1;
    int passed = 0;
    int total = 0;
    logic [7:0] pkt [0:127];
    int bcyc [0:127];
    int plen = 0;

    // cycle counter used to time pulses against the byte that caused them
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (hdr_valid) begin
            nvalid <= nvalid + 1;
            vcyc   <= cyc;
        end
        if (hdr_error) begin
            nerror <= nerror + 1;
            ecyc   <= cyc;
        end
    end

    task automatic build_pkt(input logic [3:0] ihl_v, input logic [7:0] proto,
                             input logic [7:0] b6, input logic [7:0] b7,
                             input logic [7:0] flags, input logic [15:0] win,
                             input int payload);
        int hl;
        hl = int'(ihl_v) * 4;
        for (int i = 0; i < 128; i++) pkt[i] = 8'(8'hA0 + i);
        pkt[0] = {4'h4, ihl_v}; pkt[1] = 8'h10; pkt[2] = 8'h00; pkt[3] = 8'h28;
        pkt[4] = 8'h1C; pkt[5] = 8'h46; pkt[6] = b6; pkt[7] = b7;
        pkt[8] = 8'h40; pkt[9] = proto;
        for (int i = 20; i < hl; i++) pkt[i] = 8'h01;
        for (int t = 0; t < 20; t++) pkt[hl + t] = 8'(8'h30 + t);
        pkt[hl + 12] = 8'h50;
        pkt[hl + 13] = flags;
        pkt[hl + 14] = win[15:8];
        pkt[hl + 15] = win[7:0];
        plen = hl + 20 + payload;
    endtask

    task automatic send_pkt(input int n, input bit with_eop);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_sop   = (i == 0);
            in_eop   = with_eop && (i == n - 1);
            bcyc[i]  = cyc;
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++; if (hdr_valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", hdr_valid); else passed++;
        total++; if (hdr_error !== 1'b0) $display("FAIL rst_error got %0h exp 0", hdr_error); else passed++;
        total++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) $display("FAIL rst_cnt got %0h/%0h exp 0/0", good_cnt, bad_cnt); else passed++;
        total++; if (window !== 16'd0 || tot_len !== 16'd0 || ihl !== 4'd0) $display("FAIL rst_fields got %0h/%0h/%0h exp 0", window, tot_len, ihl); else passed++;
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_minimal;
        int nv0, ne0;
        nv0 = nvalid; ne0 = nerror;
        build_pkt(4'd5, 8'h06, 8'h40, 8'h00, 8'h12, 16'hFAF0, 0);
        send_pkt(plen, 1'b1);
        idle(3);
        total++; if (nvalid - nv0 !== 1) $display("FAIL min_pulses got %0d exp 1", nvalid - nv0); else passed++;
        total++; if (vcyc !== bcyc[35] + 1) $display("FAIL min_latency got %0d exp %0d", vcyc, bcyc[35] + 1); else passed++;
        total++; if (nerror - ne0 !== 0) $display("FAIL min_err got %0d exp 0", nerror - ne0); else passed++;
        total++; if (ihl !== 4'd5 || tos !== 8'h10 || tot_len !== 16'h0028) $display("FAIL min_ip1 got %0h %0h %0h exp 5 10 28", ihl, tos, tot_len); else passed++;
        total++; if (id !== 16'h1C46 || df !== 1'b1 || frag !== 13'd0) $display("FAIL min_ip2 got %0h %0h %0h exp 1c46 1 0", id, df, frag); else passed++;
        total++; if (doff !== 4'd5 || syn !== 1'b1 || ack !== 1'b1 || fin !== 1'b0 || rst_f !== 1'b0)
            $display("FAIL min_tcp got doff=%0h s=%0b a=%0b f=%0b r=%0b exp 5 1 1 0 0", doff, syn, ack, fin, rst_f); else passed++;
        total++; if (window !== 16'hFAF0) $display("FAIL min_window got %0h exp faf0", window); else passed++;
        total++; if (good_cnt !== 16'd1) $display("FAIL min_good got %0d exp 1", good_cnt); else passed++;
    endtask

    task automatic test_options;
        int nv0;
        nv0 = nvalid;
        build_pkt(4'd7, 8'h06, 8'h00, 8'h00, 8'h01, 16'h0102, 10);
        send_pkt(plen, 1'b1);
        idle(3);
        total++; if (nvalid - nv0 !== 1) $display("FAIL opt_pulses got %0d exp 1", nvalid - nv0); else passed++;
        total++; if (vcyc !== bcyc[43] + 1) $display("FAIL opt_latency got %0d exp %0d", vcyc, bcyc[43] + 1); else passed++;
        total++; if (fin !== 1'b1 || syn !== 1'b0 || ihl !== 4'd7 || df !== 1'b0) $display("FAIL opt_fields got f=%0b s=%0b ihl=%0h df=%0b exp 1 0 7 0", fin, syn, ihl, df); else passed++;
        total++; if (window !== 16'h0102 || good_cnt !== 16'd2) $display("FAIL opt_win_cnt got %0h/%0d exp 0102/2", window, good_cnt); else passed++;
    endtask

    task automatic test_wrong_proto;
        int nv0, ne0;
        nv0 = nvalid; ne0 = nerror;
        build_pkt(4'd5, 8'h11, 8'h40, 8'h00, 8'h12, 16'h5555, 0);
        send_pkt(plen, 1'b1);
        idle(3);
        total++; if (nerror - ne0 !== 1 || nvalid - nv0 !== 0) $display("FAIL proto_pulses got err=%0d val=%0d exp 1 0", nerror - ne0, nvalid - nv0); else passed++;
        total++; if (ecyc !== bcyc[9] + 1) $display("FAIL proto_latency got %0d exp %0d", ecyc, bcyc[9] + 1); else passed++;
        total++; if (window !== 16'h0102 || ihl !== 4'd7 || fin !== 1'b1) $display("FAIL proto_hold got %0h %0h %0b exp 0102 7 1", window, ihl, fin); else passed++;
        total++; if (bad_cnt !== 16'd1) $display("FAIL proto_bad got %0d exp 1", bad_cnt); else passed++;
    endtask

    task automatic test_truncation;
        int nv0, ne0;
        nv0 = nvalid; ne0 = nerror;
        build_pkt(4'd5, 8'h06, 8'h40, 8'h00, 8'h12, 16'hFAF0, 0);
        send_pkt(31, 1'b1);
        idle(3);
        total++; if (nerror - ne0 !== 1 || nvalid - nv0 !== 0) $display("FAIL trunc_pulses got err=%0d val=%0d exp 1 0", nerror - ne0, nvalid - nv0); else passed++;
        total++; if (ecyc !== bcyc[30] + 1) $display("FAIL trunc_latency got %0d exp %0d", ecyc, bcyc[30] + 1); else passed++;
        total++; if (bad_cnt !== 16'd2) $display("FAIL trunc_bad got %0d exp 2", bad_cnt); else passed++;
    endtask

    task automatic test_sop_abort;
        int nv0, ne0;
        nv0 = nvalid; ne0 = nerror;
        build_pkt(4'd5, 8'h06, 8'h40, 8'h00, 8'h12, 16'hFAF0, 0);
        send_pkt(25, 1'b0);
        build_pkt(4'd5, 8'h06, 8'h25, 8'h11, 8'h02, 16'h1234, 4);
        send_pkt(plen, 1'b1);
        idle(3);
        total++; if (nerror - ne0 !== 1 || nvalid - nv0 !== 1) $display("FAIL abort_pulses got err=%0d val=%0d exp 1 1", nerror - ne0, nvalid - nv0); else passed++;
        total++; if (ecyc !== bcyc[0] + 1 || vcyc !== bcyc[35] + 1) $display("FAIL abort_timing got %0d/%0d exp %0d/%0d", ecyc, vcyc, bcyc[0] + 1, bcyc[35] + 1); else passed++;
        total++; if (window !== 16'h1234 || syn !== 1'b1 || ack !== 1'b0 || df !== 1'b0 || frag !== 13'h0511)
            $display("FAIL abort_fields got %0h s=%0b a=%0b df=%0b frag=%0h exp 1234 1 0 0 511", window, syn, ack, df, frag); else passed++;
        total++; if (good_cnt !== 16'd3 || bad_cnt !== 16'd3) $display("FAIL abort_cnt got %0d/%0d exp 3/3", good_cnt, bad_cnt); else passed++;
    endtask

    task automatic test_reset_mid;
        build_pkt(4'd5, 8'h06, 8'h40, 8'h00, 8'h12, 16'hFAF0, 0);
        send_pkt(11, 1'b0);
        #2 rst = 1'b1;
        #1;
        total++; if (good_cnt !== 16'd0 || bad_cnt !== 16'd0) $display("FAIL midrst_cnt got %0d/%0d exp 0/0", good_cnt, bad_cnt); else passed++;
        total++; if (window !== 16'd0 || ihl !== 4'd0 || frag !== 13'd0 || syn !== 1'b0) $display("FAIL midrst_fields got %0h %0h %0h %0b exp 0", window, ihl, frag, syn); else passed++;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        // stray mid-packet bytes without sop must be ignored
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_data = 8'h45; in_sop = 1'b0; in_eop = (i == 5);
        end
        idle(2);
        total++; if (hdr_valid !== 1'b0 || hdr_error !== 1'b0 || good_cnt !== 16'd0 || bad_cnt !== 16'd0)
            $display("FAIL stray_bytes got v=%0b e=%0b %0d/%0d exp 0", hdr_valid, hdr_error, good_cnt, bad_cnt); else passed++;
    endtask

    task automatic test_back_to_back;
        int nv0, ne0;
        nv0 = nvalid; ne0 = nerror;
        build_pkt(4'd5, 8'h06, 8'h40, 8'h00, 8'h12, 16'hFAF0, 0);
        send_pkt(plen, 1'b1);
        build_pkt(4'd5, 8'h06, 8'h00, 8'h07, 8'h04, 16'hBEEF, 0);
        send_pkt(plen, 1'b1);
        idle(3);
        total++; if (nvalid - nv0 !== 2 || nerror - ne0 !== 0) $display("FAIL b2b_pulses got val=%0d err=%0d exp 2 0", nvalid - nv0, nerror - ne0); else passed++;
        total++; if (good_cnt !== 16'd2 || d2_good !== 2'd2) $display("FAIL b2b_good got %0d/%0d exp 2/2", good_cnt, d2_good); else passed++;
        total++; if (window !== 16'hBEEF || rst_f !== 1'b1 || frag !== 13'd7) $display("FAIL b2b_fields got %0h %0b %0h exp beef 1 7", window, rst_f, frag); else passed++;
    endtask

    task automatic test_saturation;
        int nv0, ne0;
        nv0 = nvalid; ne0 = nerror;
        build_pkt(4'd5, 8'h06, 8'h40, 8'h00, 8'h12, 16'hFAF0, 0);
        pkt[0] = 8'h55;
        send_pkt(20, 1'b1);
        pkt[0] = 8'h44;
        send_pkt(20, 1'b1);
        pkt[0] = 8'h45;
        send_pkt(1, 1'b1);
        pkt[9] = 8'h11;
        send_pkt(40, 1'b1);
        pkt[9] = 8'h06;
        send_pkt(26, 1'b1);
        idle(3);
        total++; if (nerror - ne0 !== 5 || nvalid - nv0 !== 0) $display("FAIL sat_pulses got err=%0d val=%0d exp 5 0", nerror - ne0, nvalid - nv0); else passed++;
        total++; if (bad_cnt !== 16'd5) $display("FAIL sat_bad16 got %0d exp 5", bad_cnt); else passed++;
        total++; if (d2_bad !== 2'd3) $display("FAIL sat_bad2 got %0d exp 3", d2_bad); else passed++;
    endtask

    initial begin
        test_reset;
        test_minimal;
        test_options;
        test_wrong_proto;
        test_truncation;
        test_sop_abort;
        test_reset_mid;
        test_back_to_back;
        test_saturation;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
